mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_starve_cnt.sv | 38 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and legal-range constants for the two-requester memory arbiter.
package mem_arb_pkg;

  // Controller state: IDLE issues grants, RD_WAIT waits out the memory latency.
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  // Which requester owns the read currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Legal parameter ranges.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
  localparam int D_BURST_MIN = 1;
  localparam int D_BURST_LIM = 15;

  // Counter widths sized to the largest legal values above.
  localparam int LAT_W    = 2;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts data grants taken while a fetch is waiting; flags when the data
// burst allowance is used up so the fetch side gets the next grant.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == STARVE_W'(MAX));

  // Clear wins over increment; the count sticks at MAX once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-ported memory with a fixed read latency. Writes complete in the
// grant cycle; reads hold the arbiter until the data has been captured.
//
// Handshake: a requester raises req with its address/data and holds them
// until the cycle its gnt is high; that cycle is the transfer. Read data
// returns later as a one-cycle valid pulse with rdata, and rdata then holds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int D_BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic [7:0] if_addr,
  output logic       if_gnt,
  output logic [7:0] if_rdata,
  output logic       if_valid,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic [7:0] d_rdata,
  output logic       d_valid,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT out of range");
  end
  if (D_BURST_MAX < D_BURST_MIN || D_BURST_MAX > D_BURST_LIM) begin : g_bad_burst
    $error("mem_arbiter: D_BURST_MAX out of range");
  end

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       if_rdata_q, if_rdata_d;
  logic [7:0]       d_rdata_q, d_rdata_d;
  logic             if_valid_q, if_valid_d;
  logic             d_valid_q, d_valid_d;
  logic             starve_sat;
  logic             grant_ok;
  logic             if_win;
  logic             d_win;

  // Grants only from IDLE, never alongside a response pulse, never in reset.
  // Data has priority unless the fetch side has been passed over too often.
  assign grant_ok = (state_q == IDLE) && !if_valid_q && !d_valid_q && !rst;
  assign if_win   = grant_ok && if_req && (!d_req || starve_sat);
  assign d_win    = grant_ok && d_req && !if_win;

  assign if_gnt   = if_win;
  assign d_gnt    = d_win;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign busy     = (state_q != IDLE);

  arb_starve_cnt #(
    .MAX (D_BURST_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (d_win && if_req),
    .clr (if_win || !if_req),
    .sat (starve_sat)
  );

  // Next state, memory drive and response capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (if_win) begin
          mem_addr = if_addr;
          state_d  = RD_WAIT;
          owner_d  = OWN_IF;
          lat_d    = LAT_W'(MEM_LAT);
        end else if (d_win) begin
          mem_addr  = d_addr;
          mem_we    = d_we;
          mem_wdata = d_wdata;
          if (!d_we) begin
            state_d = RD_WAIT;
            owner_d = OWN_D;
            lat_d   = LAT_W'(MEM_LAT);
          end
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and response registers; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three lanes with MEM_LAT = 1, 2, 3, each with its
// own memory, transaction-level reference model and directed + random stimulus.
module tb_mem_arbiter;

  localparam int BURST = 4;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_init(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h5A;
    if (a == 16'h10) v = 8'hA5;
    return v;
  endfunction

  task automatic chk(input string nm, input int ln, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane_lat%0d t=%0t actual=%h expected=%h", nm, ln + 1,
               $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = g + 1;

    logic       rst, if_req, d_req, d_we;
    logic [7:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic       if_gnt, if_valid, d_gnt, d_valid, mem_we, busy;
    logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic       done = 1'b0;
    logic       ig_s = 1'b0;
    logic       dg_s = 1'b0;

    mem_arbiter #(
      .MEM_LAT     (LAT),
      .D_BURST_MAX (BURST)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    // Shared memory: data for an address cycle appears LAT cycles later.
    logic [7:0] phys_mem [256];
    logic [7:0] addr_pipe [3];
    bit         phys_loaded = 1'b0;
    assign mem_rdata = phys_mem[addr_pipe[LAT-1]];

    always @(posedge clk) begin
      if (!phys_loaded) begin
        for (int a = 0; a < 256; a++) phys_mem[a] = mem_init(a);
        phys_loaded = 1'b1;
      end
      if (mem_we) phys_mem[mem_addr] = mem_wdata;
      addr_pipe[0] <= mem_addr;
      addr_pipe[1] <= addr_pipe[0];
      addr_pipe[2] <= addr_pipe[1];
    end

    // Reference model: when the port is free, what is granted, when the
    // response lands and with which data. Checked every cycle.
    logic [7:0] ref_mem [256];
    bit         ref_loaded = 1'b0;
    int         m_cyc = 0;
    int         m_starve = 0;
    int         m_free = 0;
    int         m_gntc = -10;
    int         m_resp = -10;
    bit         m_pif = 1'b0;
    logic [7:0] m_pdata = '0;
    logic [7:0] m_ird = '0;
    logic [7:0] m_drd = '0;

    always @(negedge clk) begin
      bit         can, e_ig, e_dg, e_iv, e_dv, e_we, e_busy;
      logic [7:0] e_addr, e_wd;
      if (!ref_loaded) begin
        for (int a = 0; a < 256; a++) ref_mem[a] = mem_init(a);
        ref_loaded = 1'b1;
      end
      e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_we = 0; e_busy = 0;
      e_addr = '0; e_wd = '0;
      if (rst) begin
        m_starve = 0; m_free = 0; m_gntc = -10; m_resp = -10;
        m_ird = '0; m_drd = '0;
      end else begin
        can  = (m_cyc >= m_free);
        e_ig = can && if_req && (!d_req || m_starve == BURST);
        e_dg = can && d_req && !e_ig;
        if (e_ig) begin
          e_addr = if_addr;
        end else if (e_dg) begin
          e_addr = d_addr; e_we = d_we;
          if (d_we) e_wd = d_wdata;
        end
        e_busy = (m_cyc > m_gntc) && (m_cyc < m_resp);
        if (m_cyc == m_resp) begin
          if (m_pif) begin e_iv = 1; m_ird = m_pdata; end
          else begin e_dv = 1; m_drd = m_pdata; end
        end
      end
      chk("if_gnt", g, 8'(if_gnt), 8'(e_ig));
      chk("d_gnt", g, 8'(d_gnt), 8'(e_dg));
      chk("if_valid", g, 8'(if_valid), 8'(e_iv));
      chk("d_valid", g, 8'(d_valid), 8'(e_dv));
      chk("busy", g, 8'(busy), 8'(e_busy));
      chk("mem_we", g, 8'(mem_we), 8'(e_we));
      chk("mem_addr", g, mem_addr, e_addr);
      if (!(e_dg && !d_we)) chk("mem_wdata", g, mem_wdata, e_wd);
      chk("if_rdata", g, if_rdata, m_ird);
      chk("d_rdata", g, d_rdata, m_drd);
      if (!rst) begin
        if (e_ig || (e_dg && !d_we)) begin
          m_gntc  = m_cyc;
          m_resp  = m_cyc + LAT + 1;
          m_free  = m_cyc + LAT + 2;
          m_pif   = e_ig;
          m_pdata = ref_mem[e_addr];
        end
        if (e_dg && d_we) ref_mem[d_addr] = d_wdata;
        if (!if_req || e_ig) m_starve = 0;
        else if (e_dg && m_starve < BURST) m_starve++;
      end
      ig_s = if_gnt;
      dg_s = d_gnt;
      m_cyc++;
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Directed scenarios with hand-computed expectations, then random traffic.
    initial begin
      logic [7:0] wa [3];
      logic [7:0] wd [3];
      wa[0] = 8'h01; wa[1] = 8'h02; wa[2] = 8'h03;
      wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
      rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Lone fetch of 0x10; a second fetch held behind it.
      if_req = 1; if_addr = 8'h10;
      @(negedge clk); chk("t1_gnt0", g, 8'(if_gnt), 8'h01);
      tick();
      repeat (LAT) tick();
      @(negedge clk);
      chk("t1_valid", g, 8'(if_valid), 8'h01);
      chk("t1_rdata", g, if_rdata, 8'hA5);
      chk("t1_no_gnt_on_valid", g, 8'(if_gnt), 8'h00);
      tick();
      @(negedge clk); chk("t1_gnt_next", g, 8'(if_gnt), 8'h01);
      tick(); if_req = 0;
      repeat (LAT + 2) tick();

      // Simultaneous fetch and data read: data first.
      if_req = 1; if_addr = 8'h30; d_req = 1; d_we = 0; d_addr = 8'h20;
      @(negedge clk);
      chk("t2_dgnt", g, 8'(d_gnt), 8'h01);
      chk("t2_ifgnt0", g, 8'(if_gnt), 8'h00);
      tick(); d_req = 0;
      repeat (LAT) tick();
      @(negedge clk);
      chk("t2_dvalid", g, 8'(d_valid), 8'h01);
      chk("t2_drdata", g, d_rdata, 8'h7A);
      tick();
      @(negedge clk); chk("t2_ifgnt", g, 8'(if_gnt), 8'h01);
      tick(); if_req = 0;
      repeat (LAT + 2) tick();

      // Three back-to-back writes, then read one back.
      for (int k = 0; k < 3; k++) begin
        d_req = 1; d_we = 1; d_addr = wa[k]; d_wdata = wd[k];
        @(negedge clk);
        chk("t3_dgnt", g, 8'(d_gnt), 8'h01);
        chk("t3_we", g, 8'(mem_we), 8'h01);
        chk("t3_busy", g, 8'(busy), 8'h00);
        chk("t3_dvalid", g, 8'(d_valid), 8'h00);
        tick();
      end
      d_we = 0; d_addr = 8'h02;
      @(negedge clk); chk("t3_rd_gnt", g, 8'(d_gnt), 8'h01);
      tick(); d_req = 0;
      repeat (LAT) tick();
      @(negedge clk);
      chk("t3_rd_valid", g, 8'(d_valid), 8'h01);
      chk("t3_rd_data", g, d_rdata, 8'h22);
      repeat (2) tick();

      // Held fetch against a continuous write stream.
      if_req = 1; if_addr = 8'h40;
      for (int k = 0; k < 4; k++) begin
        d_req = 1; d_we = 1; d_addr = 8'h50 + 8'(k); d_wdata = 8'($urandom);
        @(negedge clk);
        chk("t4_dgnt", g, 8'(d_gnt), 8'h01);
        chk("t4_ifwait", g, 8'(if_gnt), 8'h00);
        tick();
      end
      d_addr = 8'h54; d_wdata = 8'($urandom);
      @(negedge clk);
      chk("t4_ifgnt", g, 8'(if_gnt), 8'h01);
      chk("t4_dwait", g, 8'(d_gnt), 8'h00);
      tick(); if_req = 0;
      repeat (LAT + 1) tick();
      @(negedge clk); chk("t4_dresume", g, 8'(d_gnt), 8'h01);
      tick(); d_req = 0;
      repeat (2) tick();

      // Reset while a fetch is in flight.
      if_req = 1; if_addr = 8'h10;
      @(negedge clk); chk("t5_gnt", g, 8'(if_gnt), 8'h01);
      tick();
      repeat ((LAT > 1) ? 1 : 0) tick();
      rst = 1; d_req = 1; d_we = 0; d_addr = 8'h20;
      @(negedge clk);
      chk("t5_busy", g, 8'(busy), 8'h00);
      chk("t5_ivalid", g, 8'(if_valid), 8'h00);
      chk("t5_dvalid", g, 8'(d_valid), 8'h00);
      chk("t5_irdata", g, if_rdata, 8'h00);
      chk("t5_drdata", g, d_rdata, 8'h00);
      chk("t5_grants", g, {6'd0, if_gnt, d_gnt}, 8'h00);
      chk("t5_we", g, 8'(mem_we), 8'h00);
      tick(); tick();
      rst = 0; if_req = 0; d_req = 0;
      for (int j = 0; j < LAT + 3; j++) begin
        @(negedge clk);
        chk("t5_no_valid", g, {6'd0, if_valid, d_valid}, 8'h00);
        tick();
      end

      // Random traffic with occasional reset pulses.
      for (int n = 0; n < 800; n++) begin
        rst = ($urandom_range(0, 149) == 0);
        if (!if_req || ig_s) begin
          if_req  = ($urandom_range(0, 99) < 50);
          if_addr = 8'($urandom_range(0, 31));
        end
        if (!d_req || dg_s) begin
          d_req   = ($urandom_range(0, 99) < 75);
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = 8'($urandom_range(0, 31));
          d_wdata = 8'($urandom);
        end
        tick();
      end
      rst = 0; if_req = 0; d_req = 0;
      repeat (LAT + 3) tick();
      done = 1'b1;
    end
  end

  // Wait for all lanes with a cycle budget, then report.
  initial begin
    for (int t = 0; t < 20000; t++) begin
      @(posedge clk);
      if (lane[0].done && lane[1].done && lane[2].done) break;
    end
    #2;
    if (!(lane[0].done && lane[1].done && lane[2].done)) begin
      errors++;
      $display("FAIL timeout lanes_done actual=%b%b%b expected=111",
               lane[2].done, lane[1].done, lane[0].done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
